// File: rtl/sr_target_emu.sv
// sr_target_emu: emulates a serial shift-register target driven by an asynchronous controller.
// Ports:
//    clk_in    - system clock, all state on its rising edge
//    rst       - synchronous active-high reset
//    sr_clk    - controller shift clock (asynchronous, synchronised here)
//    sr_din    - controller serial data, sampled on sr_clk rises
//    sr_load   - controller load strobe, acts on its rising edge only
//    sr_dout   - serial data back to the controller
//    cfg_out   - configuration word captured at each load
//    cfg_valid - one-cycle pulse when cfg_out updates
//    len_err   - one-cycle pulse with cfg_valid when the bit count was not WIDTH
//    bit_count - saturating count of sr_clk rises since the last load or reset
module sr_target_emu #(
   parameter int WIDTH = 170,
   parameter int CNT_WIDTH = 8,
   parameter int SHIFT_DIRECTION = 1,
   parameter logic [WIDTH-1:0] INIT_PATTERN = {WIDTH{1'b0}}
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 sr_clk,
   input  logic                 sr_din,
   input  logic                 sr_load,
   output logic                 sr_dout,
   output logic [WIDTH-1:0]     cfg_out,
   output logic                 cfg_valid,
   output logic                 len_err,
   output logic [CNT_WIDTH-1:0] bit_count
);
   typedef enum logic [1:0] {IDLE, SHIFTING, FULL, OVER} state_t;
   localparam logic [CNT_WIDTH-1:0] W_CNT = CNT_WIDTH'(WIDTH);
   logic clk_s1, clk_s2, clk_s3;
   logic din_s1, din_s2;
   logic ld_s1, ld_s2, ld_s3;
   logic upd, rise, ld_rise, out_bit;
   logic [WIDTH-1:0] sreg, sh_val;
   logic [CNT_WIDTH-1:0] cnt_inc;
   state_t state, st_nx;
   // st_nx is the state after this cycle's shift, so a load arriving together
   // with the final bit is judged on the completed count.
   always_comb begin
      rise = clk_s2 & ~clk_s3;
      ld_rise = ld_s2 & ~ld_s3;
      sh_val = (SHIFT_DIRECTION != 0) ? {sreg[WIDTH-2:0], din_s2} : {din_s2, sreg[WIDTH-1:1]};
      out_bit = (SHIFT_DIRECTION != 0) ? sreg[WIDTH-1] : sreg[0];
      cnt_inc = (&bit_count) ? bit_count : bit_count + 1'b1;
      st_nx = !rise ? state :
              (cnt_inc == W_CNT) ? FULL :
              (state == IDLE) ? SHIFTING :
              (state == FULL) ? OVER : state;
   end
   always_ff @(posedge clk_in) begin
      if (rst) begin
         {clk_s1, clk_s2, clk_s3} <= '0;
         {din_s1, din_s2} <= '0;
         {ld_s1, ld_s2, ld_s3} <= '0;
         upd <= 1'b0;
         sreg <= INIT_PATTERN;
         sr_dout <= 1'b0;
         cfg_out <= '0;
         cfg_valid <= 1'b0;
         len_err <= 1'b0;
         bit_count <= '0;
         state <= IDLE;
      end else begin
         clk_s1 <= sr_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         din_s1 <= sr_din;
         din_s2 <= din_s1;
         ld_s1 <= sr_load;
         ld_s2 <= ld_s1;
         ld_s3 <= ld_s2;
         upd <= rise;
         if (rise) sreg <= sh_val;
         if (upd) sr_dout <= out_bit;
         cfg_valid <= ld_rise;
         len_err <= ld_rise && (st_nx != FULL);
         if (ld_rise) begin
            cfg_out <= rise ? sh_val : sreg;
            bit_count <= '0;
            state <= IDLE;
         end else begin
            bit_count <= rise ? cnt_inc : bit_count;
            state <= st_nx;
         end
      end
   end
endmodule

// File: tb/tb_sr_target_emu.sv
// tb_sr_target_emu: randomized directed bench for sr_target_emu in both shift directions.
module tb_sr_target_emu;
   localparam int W = 170;
   localparam logic [W-1:0] INIT1 = {10{17'h1A5C3}};
   logic clk_in = 1'b0, rst = 1'b1, sr_clk = 1'b0, sr_din = 1'b0, sr_load = 1'b0;
   logic dout1, dout0, cv1, cv0, le1, le0;
   logic [W-1:0] cfg1, cfg0;
   logic [7:0] bc1, bc0;
   logic [W-1:0] m1 = INIT1, m0 = '0, dcap = '0, wa, wb, pat;
   logic e1 = 1'b0, e0 = 1'b0;
   int cnt = 0, compared = 0, mismatched = 0;

   always #5 clk_in = ~clk_in;

   sr_target_emu #(.WIDTH(W), .CNT_WIDTH(8), .SHIFT_DIRECTION(1), .INIT_PATTERN(INIT1)) u1 (
      .clk_in(clk_in), .rst(rst), .sr_clk(sr_clk), .sr_din(sr_din), .sr_load(sr_load),
      .sr_dout(dout1), .cfg_out(cfg1), .cfg_valid(cv1), .len_err(le1), .bit_count(bc1));
   sr_target_emu #(.WIDTH(W), .CNT_WIDTH(8), .SHIFT_DIRECTION(0)) u0 (
      .clk_in(clk_in), .rst(rst), .sr_clk(sr_clk), .sr_din(sr_din), .sr_load(sr_load),
      .sr_dout(dout0), .cfg_out(cfg0), .cfg_valid(cv0), .len_err(le0), .bit_count(bc0));

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Reference: the word as a number, MSB-first appends at the bottom,
   // LSB-first inserts at the top; the returned bit is the end nearest the exit.
   task automatic mshift(input logic b);
      m1 = (m1 << 1) | W'(b);
      m0 = (m0 >> 1) | (W'(b) << (W - 1));
      cnt = (cnt < 255) ? cnt + 1 : 255;
      e1 = m1[W-1];
      e0 = m0[0];
   endtask

   function automatic logic [W-1:0] rword();
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   task automatic sr_bit(input logic b);
      int stray;
      stray = 0;
      sr_din = b;
      sr_clk = 1'b1;
      chk("dout_msb", W'(dout1), W'(e1));
      chk("dout_lsb", W'(dout0), W'(e0));
      dcap = (dcap << 1) | W'(dout1);
      mshift(b);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) sr_clk = 1'b0;
         cyc(1);
         if (cv1 || le1 || cv0 || le0) stray++;
      end
      chk("stray_pulse", W'(stray), W'(0));
      chk("bit_count", W'(bc1), W'(cnt));
      chk("bit_count0", W'(bc0), W'(cnt));
   endtask

   task automatic rbits(input int n);
      for (int i = 0; i < n; i++) sr_bit(1'($urandom_range(0, 1)));
   endtask

   task automatic send_msb(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) sr_bit(w[i]);
   endtask

   // Load with optional simultaneous final bit; release=0 leaves sr_load high.
   task automatic do_load(input bit simul, input logic b, input bit release_);
      int pv, pe;
      logic [W-1:0] c1, c0;
      logic l1, l0, err;
      pv = 0; pe = 0; c1 = 'x; c0 = 'x; l1 = 1'bx; l0 = 1'bx;
      if (simul) begin
         sr_din = b;
         sr_clk = 1'b1;
         mshift(b);
      end
      sr_load = 1'b1;
      err = (cnt != W);
      for (int i = 0; i < 14; i++) begin
         if (i == 8) begin
            sr_clk = 1'b0;
            if (release_) sr_load = 1'b0;
         end
         cyc(1);
         if (cv1) begin
            pv++; c1 = cfg1; c0 = cfg0; l1 = le1; l0 = le0;
         end
         if (le1) pe++;
      end
      cnt = 0;
      chk("valid_pulses", W'(pv), W'(1));
      chk("err_pulses", W'(pe), W'(err));
      chk("cfg_msb", c1, m1);
      chk("cfg_lsb", c0, m0);
      chk("len_err_msb", W'(l1), W'(err));
      chk("len_err_lsb", W'(l0), W'(err));
      chk("count_clear", W'(bc1), W'(0));
   endtask

   task automatic reset_check(input string tag);
      int stray;
      stray = 0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         if (cv1 || le1 || cv0 || le0) stray++;
      end
      rst = 1'b0;
      m1 = INIT1; m0 = '0; cnt = 0; e1 = 1'b0; e0 = 1'b0;
      chk({tag, "_pulse"}, W'(stray), W'(0));
      chk({tag, "_cfg1"}, cfg1, '0);
      chk({tag, "_cfg0"}, cfg0, '0);
      chk({tag, "_dout"}, W'({dout1, dout0}), W'(0));
      chk({tag, "_cnt"}, W'({bc1, bc0}), W'(0));
   endtask

   initial begin
      reset_check("rst0");
      cyc(2);
      // Load straight after reset exposes INIT_PATTERN and flags a length error.
      do_load(0, 1'b0, 1);
      chk("init_pattern", cfg1, INIT1);
      // Alternating pattern, full-length transfer.
      pat = {85{2'b10}};
      send_msb(pat);
      do_load(0, 1'b0, 1);
      chk("pattern_cfg", cfg1, pat);
      // Read-back of the previous word while shifting a new one.
      for (int k = 0; k < 2; k++) begin
         wa = rword();
         send_msb(wa);
         do_load(0, 1'b0, 1);
         wb = rword();
         dcap = '0;
         send_msb(wb);
         chk("readback", dcap, wa);
         do_load(0, 1'b0, 1);
         chk("cfg_b", cfg1, wb);
      end
      // Short and long transfers.
      rbits(169);
      do_load(0, 1'b0, 1);
      rbits(171);
      do_load(0, 1'b0, 1);
      // Final bit coincides with the load rise.
      rbits(169);
      do_load(1, 1'($urandom_range(0, 1)), 1);
      // Load held high: no retrigger, shifts still apply.
      do_load(0, 1'b0, 0);
      wa = rword();
      send_msb(wa);
      sr_load = 1'b0;
      cyc(4);
      do_load(0, 1'b0, 1);
      chk("held_load_cfg", cfg1, wa);
      // Counter saturation.
      rbits(300);
      chk("saturate", W'(bc1), W'(255));
      do_load(0, 1'b0, 1);
      // Reset mid-transfer.
      rbits(80);
      reset_check("rst_mid");
      do_load(0, 1'b0, 1);
      chk("init_after_rst", cfg1, INIT1);
      // LSB-first: a single one at the top, sent low bit first.
      pat = W'(1) << (W - 1);
      for (int i = 0; i < W; i++) sr_bit(pat[i]);
      do_load(0, 1'b0, 1);
      chk("lsb_first_cfg", cfg0, W'(1) << (W - 1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/sr_target_emu.md
SR_TARGET_EMU -- requirements
Module: sr_target_emu

Interface
REQ-001 SHALL have parameter WIDTH, default 170, length of the emulated shift register in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, bit-counter width; WIDTH SHALL NOT exceed 2**CNT_WIDTH-2.
REQ-003 SHALL have parameter SHIFT_DIRECTION, default 1: 1 = MSB out first, 0 = LSB out first.
REQ-004 SHALL have parameter INIT_PATTERN, default {WIDTH{1'b0}}: reset content of the shift register.
REQ-005 clk_in  input  1  sole clock; every register is clocked on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 sr_clk  input  1  shift clock from the controller; asynchronous to clk_in.
REQ-008 sr_din  input  1  serial data from the controller.
REQ-009 sr_load  input  1  load strobe from the controller.
REQ-010 sr_dout  output  1  serial data returned to the controller.
REQ-011 cfg_out  output  WIDTH  latched configuration word.
REQ-012 cfg_valid  output  1  one-cycle pulse when cfg_out updates.
REQ-013 len_err  output  1  one-cycle pulse when a load follows a bit count other than WIDTH.
REQ-014 bit_count  output  CNT_WIDTH  sr_clk rising edges since the last load or reset.

Function
REQ-015 sr_clk, sr_din and sr_load SHALL each pass through a 2-flop synchroniser; sr_din SHALL use the same stage depth as sr_clk so that the two stay aligned.
REQ-016 Edge detect SHALL compare synchronised stage 2 with a stage-3 register: rise = s2 & ~s3.
REQ-017 The shift register SHALL update on the clk_in edge at which the sr_clk rise is asserted, which is the 3rd clk_in edge after the first edge that samples sr_clk high.
REQ-018 Shift for SHIFT_DIRECTION=1: sreg <= {sreg[WIDTH-2:0], din_s2}.
REQ-019 Shift for SHIFT_DIRECTION=0: sreg <= {din_s2, sreg[WIDTH-1:1]}.
REQ-020 sr_dout SHALL be a register loaded one cycle after each sreg update.
REQ-021 sr_dout SHALL take sreg[WIDTH-1] when SHIFT_DIRECTION=1 and sreg[0] when SHIFT_DIRECTION=0.
REQ-022 sr_dout SHALL otherwise hold its value.
REQ-023 Operation is only required to be correct when the sr_clk high and low times are each at least 3 clk_in periods (controller div >= 3).
REQ-024 The FSM SHALL have states IDLE, SHIFTING, FULL and OVER.
REQ-025 FSM transitions: IDLE -> SHIFTING on the first rise; SHIFTING -> FULL when bit_count reaches WIDTH; FULL -> OVER on a further rise.
REQ-026 bit_count SHALL increment by 1 per rise and saturate at 2**CNT_WIDTH-1 with no wrap-around.
REQ-027 On an sr_load rise: cfg_out <= sreg; cfg_valid = 1 for exactly one cycle; bit_count <= 0; state <= IDLE.
REQ-028 len_err SHALL pulse together with cfg_valid when the state is not FULL at the load rise; cfg_out SHALL still update.
REQ-029 A load rise in IDLE SHALL pulse both cfg_valid and len_err, and cfg_out SHALL receive the unchanged sreg.
REQ-030 When an sr_clk rise and an sr_load rise occur in the same cycle, the shift SHALL be applied first.
REQ-031 In that case cfg_out SHALL capture the post-shift sreg, and bit_count SHALL be evaluated including that bit, then cleared.
REQ-032 An sr_load level held high SHALL NOT retrigger; only its rising edge acts.
REQ-033 sr_clk rises while sr_load is high SHALL still shift.
REQ-034 sreg SHALL NOT be cleared by a load, so a subsequent shift sequence reads back the previous content.

Reset
REQ-035 While rst is high at a clk_in edge: sreg <= INIT_PATTERN; cfg_out <= 0; cfg_valid, len_err, sr_dout <= 0; bit_count <= 0; state <= IDLE; all synchroniser and edge registers <= 0.
REQ-036 Reset asserted mid-shift SHALL abort the transfer with no cfg_valid or len_err pulse.
REQ-037 The first sr_clk rise counted after reset SHALL be the first 0->1 transition seen after the synchroniser has been cleared.

Verification
REQ-038 Bench SHALL cover: WIDTH=170, SHIFT_DIRECTION=1, shift 170 bits of 170'h2AA..A then pulse load -> cfg_out=170'h2AA..A, cfg_valid one cycle, len_err=0, bit_count returns to 0.
REQ-039 Bench SHALL cover: shift word A (170 bits) and load, then shift word B (170 bits) -> the sr_dout bits sampled at each sr_clk rise during B equal A MSB-first; the second load gives cfg_out=B.
REQ-040 Bench SHALL cover: 169 rises then load -> cfg_valid and len_err pulse together; 171 rises then load -> same.
REQ-041 Bench SHALL cover: sr_clk rise and sr_load rise in the same cycle after 169 rises -> FULL is reached, len_err=0, and cfg_out includes the 170th bit.
REQ-042 Bench SHALL cover: 300 rises with CNT_WIDTH=8 -> bit_count saturates at 255 with no wrap.
REQ-043 Bench SHALL cover: rst asserted after 80 rises -> outputs at reset values, sreg=INIT_PATTERN, no cfg_valid.
REQ-044 Bench SHALL cover: SHIFT_DIRECTION=0 with the single-bit pattern 1 followed by 169 zeros -> cfg_out=170'h1 << 169.
